// File: rtl/stall_ctrl.sv
// Pipeline stall controller: merges IF/ID/EX/MEM stall requests into a
// per-stage hold vector and sequences multi-cycle EX operations.
module stall_ctrl #(
   parameter int MC_CYCLES = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       stall_req_if,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_rs_read,
   input  logic       id_rt_read,
   input  logic       ex_mem_to_regfile,
   input  logic [4:0] ex_rn,
   input  logic       ex_mc_op,
   input  logic       mem_req,
   input  logic       mem_ack,
   input  logic       flush,
   output logic [5:0] stall,
   output logic       mc_start,
   output logic       mc_busy,
   output logic       mc_done,
   output logic       load_use
);

   // state   | meaning
   // IDLE    | no multi-cycle op in flight; a new one may start
   // BUSY    | divider running, counter counts down to zero
   // DONE    | EX result valid; held while MEM is stalled

   localparam int CNT_W = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic req_if, req_id, req_ex, req_mem;
   logic rs_hit, rt_hit;

   always_comb begin
      rs_hit  = id_rs_read && (id_rs == ex_rn);
      rt_hit  = id_rt_read && (id_rt == ex_rn);
      req_if  = stall_req_if;
      req_id  = ex_mem_to_regfile && (ex_rn != 5'd0) && (rs_hit || rt_hit);
      req_ex  = ((state_q == ST_IDLE) && ex_mc_op) || (state_q == ST_BUSY);
      req_mem = mem_req && !mem_ack;
   end

   always_comb begin
      stall    = 6'b000000;
      load_use = 1'b0;
      mc_start = 1'b0;
      if (!reset && !flush) begin
         load_use = req_id;
         mc_start = (state_q == ST_IDLE) && ex_mc_op;
         if (req_mem)     stall = 6'b011111;
         else if (req_ex) stall = 6'b001111;
         else if (req_id) stall = 6'b000111;
         else if (req_if) stall = 6'b000011;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (reset || flush) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (ex_mc_op) begin
                  state_d = ST_BUSY;
                  cnt_d   = CNT_LOAD;
               end
            end
            ST_BUSY: begin
               // Decrement only when non-zero so the counter never wraps.
               if (cnt_q == '0) state_d = ST_DONE;
               else             cnt_d   = cnt_q - 1'b1;
            end
            ST_DONE: begin
               if (!req_mem) state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
      busy_d = (state_d == ST_BUSY);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Gated so every output reads zero while reset is held, even before
   // the first reset edge has cleared the state flops.
   assign mc_busy = busy_q && !reset;
   assign mc_done = done_q && !reset;

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed scenarios followed by
// randomized traffic compared against a cycle-age reference model.
module tb_stall_ctrl;

   localparam int MC = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       stall_req_if;
   logic [4:0] id_rs, id_rt, ex_rn;
   logic       id_rs_read, id_rt_read;
   logic       ex_mem_to_regfile, ex_mc_op;
   logic       mem_req, mem_ack, flush;
   logic [5:0] stall;
   logic       mc_start, mc_busy, mc_done, load_use;

   int n_checks = 0;
   int n_errors = 0;

   // Model: -1 = no op in flight; 1..MC = busy cycle index; MC+1 = result held.
   int age = -1;

   logic [5:0] obs_stall;
   logic       obs_start, obs_busy, obs_done, obs_lu;

   stall_ctrl #(.MC_CYCLES(MC)) dut (
      .clk               (clk),
      .reset             (reset),
      .stall_req_if      (stall_req_if),
      .id_rs             (id_rs),
      .id_rt             (id_rt),
      .id_rs_read        (id_rs_read),
      .id_rt_read        (id_rt_read),
      .ex_mem_to_regfile (ex_mem_to_regfile),
      .ex_rn             (ex_rn),
      .ex_mc_op          (ex_mc_op),
      .mem_req           (mem_req),
      .mem_ack           (mem_ack),
      .flush             (flush),
      .stall             (stall),
      .mc_start          (mc_start),
      .mc_busy           (mc_busy),
      .mc_done           (mc_done),
      .load_use          (load_use)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      reset = 1'b0; stall_req_if = 1'b0;
      id_rs = 5'd0; id_rt = 5'd0; id_rs_read = 1'b0; id_rt_read = 1'b0;
      ex_mem_to_regfile = 1'b0; ex_rn = 5'd0; ex_mc_op = 1'b0;
      mem_req = 1'b0; mem_ack = 1'b0; flush = 1'b0;
   endtask

   function automatic logic model_lu();
      return ex_mem_to_regfile && ex_rn != 5'd0 &&
             ((id_rs_read && id_rs == ex_rn) || (id_rt_read && id_rt == ex_rn));
   endfunction

   function automatic logic model_busy();
      return age >= 1 && age <= MC;
   endfunction

   // One cycle: compare mid-cycle, then advance the model at the edge.
   task automatic step();
      logic       lu, rq_ex, rq_mem, quiet;
      int         lvl;
      logic [5:0] e_stall;
      @(negedge clk);
      quiet  = reset || flush;
      lu     = model_lu();
      rq_ex  = (age == -1 && ex_mc_op) || model_busy();
      rq_mem = mem_req && !mem_ack;
      lvl = 0;
      if (stall_req_if) lvl = 2;
      if (lu)           lvl = 3;
      if (rq_ex)        lvl = 4;
      if (rq_mem)       lvl = 5;
      e_stall = quiet ? 6'd0 : 6'((1 << lvl) - 1);
      obs_stall = stall; obs_start = mc_start; obs_busy = mc_busy;
      obs_done = mc_done; obs_lu = load_use;
      chk("stall",    32'(stall),    32'(e_stall));
      chk("load_use", 32'(load_use), 32'(lu && !quiet));
      chk("mc_start", 32'(mc_start), 32'(age == -1 && ex_mc_op && !quiet));
      chk("mc_busy",  32'(mc_busy),  32'(model_busy() && !reset));
      chk("mc_done",  32'(mc_done),  32'(age == MC + 1 && !reset));
      @(posedge clk);
      if (quiet)                   age = -1;
      else if (age == -1)          age = ex_mc_op ? 1 : -1;
      else if (age <= MC)          age = age + 1;
      else if (!rq_mem)            age = -1;
      #1;
   endtask

   initial begin
      idle_inputs();
      // Reset with every request source active.
      reset = 1'b1; stall_req_if = 1'b1; ex_mc_op = 1'b1; mem_req = 1'b1;
      ex_mem_to_regfile = 1'b1; ex_rn = 5'd3; id_rs = 5'd3; id_rs_read = 1'b1;
      flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_stall", 32'(obs_stall), 32'd0);
         chk("rst_mc", 32'({obs_start, obs_busy, obs_done}), 32'd0);
      end
      idle_inputs();
      step();
      chk("post_rst_stall", 32'(obs_stall), 32'd0);

      // Load-use: one stall cycle, then the load has left EX.
      ex_mem_to_regfile = 1'b1; ex_rn = 5'd5; id_rs = 5'd5; id_rs_read = 1'b1;
      step();
      chk("lu_stall", 32'(obs_stall), 32'h07);
      chk("lu_flag",  32'(obs_lu), 32'd1);
      ex_mem_to_regfile = 1'b0;
      step();
      chk("lu_gone", 32'(obs_stall), 32'h00);
      ex_mem_to_regfile = 1'b1; ex_rn = 5'd0; id_rs = 5'd0;
      step();
      chk("lu_r0", 32'(obs_stall), 32'h00);
      idle_inputs();

      // Multi-cycle op, MEM idle.
      ex_mc_op = 1'b1;
      step();
      chk("mc_t0_start", 32'(obs_start), 32'd1);
      chk("mc_t0_stall", 32'(obs_stall), 32'h0F);
      for (int k = 1; k <= MC; k++) begin
         step();
         chk("mc_busy_stall", 32'(obs_stall), 32'h0F);
         chk("mc_busy_flag",  32'(obs_busy), 32'd1);
      end
      step();
      chk("mc_done_flag",  32'(obs_done), 32'd1);
      chk("mc_done_stall", 32'(obs_stall), 32'h00);
      ex_mc_op = 1'b0;
      step();
      chk("mc_back_idle", 32'({obs_busy, obs_done}), 32'd0);

      // Multi-cycle op overlapped with a long MEM stall.
      ex_mc_op = 1'b1;
      for (int k = 0; k <= 10; k++) begin
         mem_req = (k >= 2 && k <= 9);
         mem_ack = (k == 9);
         if (k == 10) ex_mc_op = 1'b0;
         step();
         if (k >= 2 && k <= 8) chk("mem_stall", 32'(obs_stall), 32'h1F);
         if (k >= 5 && k <= 9) chk("mem_done_hold", 32'(obs_done), 32'd1);
         if (k == 10) chk("mem_idle", 32'({obs_busy, obs_done}), 32'd0);
      end
      idle_inputs();

      // Flush during BUSY, op still present -> restart right after.
      ex_mc_op = 1'b1;
      step(); step();
      flush = 1'b1;
      step();
      chk("flush_stall", 32'(obs_stall), 32'h00);
      flush = 1'b0;
      step();
      chk("flush_restart", 32'(obs_start), 32'd1);
      ex_mc_op = 1'b0;
      flush = 1'b1;
      step();
      idle_inputs();

      // Priority: IF+ID gives ID level, adding MEM gives MEM level.
      stall_req_if = 1'b1; ex_mem_to_regfile = 1'b1; ex_rn = 5'd7;
      id_rt = 5'd7; id_rt_read = 1'b1;
      step();
      chk("prio_id", 32'(obs_stall), 32'h07);
      mem_req = 1'b1;
      step();
      chk("prio_mem", 32'(obs_stall), 32'h1F);
      idle_inputs();
      step();

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         reset             = ($urandom_range(0, 199) == 0);
         flush             = ($urandom_range(0, 39) == 0);
         stall_req_if      = ($urandom_range(0, 3) == 0);
         id_rs             = 5'($urandom_range(0, 3));
         id_rt             = 5'($urandom_range(0, 3));
         id_rs_read        = 1'($urandom_range(0, 1));
         id_rt_read        = 1'($urandom_range(0, 1));
         ex_mem_to_regfile = ($urandom_range(0, 3) == 0);
         ex_rn             = 5'($urandom_range(0, 3));
         ex_mc_op          = ($urandom_range(0, 4) == 0);
         mem_req           = ($urandom_range(0, 2) == 0);
         mem_ack           = ($urandom_range(0, 2) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
